alu_result_tx: RTL and testbench

ALU_RESULT_TX -- requirements
Module: alu_result_tx

---
 rtl/alu_result_tx_pkg.sv | 17 +
 rtl/alu_result_tx.sv | 91 +++++++++
 tb/tb_alu_result_tx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_tx_pkg.sv
// Shared ALU system constants: datapath widths and the result-transmit FSM encoding.
package alu_result_tx_pkg;

  localparam int ALU_RESULT_WIDTH = 16;
  localparam int ALU_BYTE_WIDTH   = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND_LO = 3'd1;
  localparam logic [2:0] ST_WAIT_LO = 3'd2;
  localparam logic [2:0] ST_SEND_HI = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;

  function automatic logic is_send_state(input logic [2:0] st);
    return (st == ST_SEND_LO) || (st == ST_SEND_HI);
  endfunction

endpackage

// File: rtl/alu_result_tx.sv
// Serialises a captured ALU result into one or two bytes for a UART transmitter,
// handshaking on TX_BUSY and flagging results that arrive while a transfer is in flight.
module alu_result_tx
  import alu_result_tx_pkg::*;
#(
  parameter int RESULT_WIDTH = ALU_RESULT_WIDTH,
  parameter int BYTE_WIDTH   = ALU_BYTE_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [RESULT_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  input  logic                    WIDE,
  input  logic                    TX_BUSY,
  output logic [BYTE_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    BUSY,
  output logic                    OVERRUN
);

  logic [2:0]              state;
  logic [2:0]              next_state;
  logic [RESULT_WIDTH-1:0] result_q;
  logic                    wide_q;
  logic [BYTE_WIDTH-1:0]   next_data;
  logic                    capture;

  // Results are only ever taken from IDLE; anything else is an overrun.
  assign capture = (state == ST_IDLE) && OUT_VALID;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    next_state = state;
    next_data  = TX_P_DATA;
    case (state)
      ST_IDLE: begin
        if (OUT_VALID) begin
          next_state = ST_SEND_LO;
          // The result register is not loaded yet, so take the low byte straight from the bus.
          next_data  = ALU_OUT[BYTE_WIDTH-1:0];
        end
      end
      ST_SEND_LO: begin
        next_data = result_q[BYTE_WIDTH-1:0];
        if (!TX_BUSY) next_state = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (TX_BUSY) begin
          if (wide_q) begin
            next_state = ST_SEND_HI;
            next_data  = result_q[RESULT_WIDTH-1:BYTE_WIDTH];
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      ST_SEND_HI: begin
        if (!TX_BUSY) next_state = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (TX_BUSY) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the async reset also clears the result register
  // so an aborted transfer can never leak a stale byte after release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      BUSY      <= 1'b0;
      OVERRUN   <= 1'b0;
      result_q  <= '0;
      wide_q    <= 1'b0;
    end else begin
      state     <= next_state;
      TX_P_DATA <= next_data;
      TX_D_VLD  <= is_send_state(next_state);
      BUSY      <= (next_state != ST_IDLE);
      OVERRUN   <= OUT_VALID && (state != ST_IDLE);
      if (capture) begin
        result_q <= ALU_OUT;
        wide_q   <= WIDE;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: a transfer-level model of capture, byte stream and overrun,
// driven by a table of results, hand sequences and random traffic with a modelled UART.
module tb_alu_result_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] alu_out = '0;
  logic        out_valid = 1'b0;
  logic        wide = 1'b0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_p_data;
  logic        tx_d_vld;
  logic        busy;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;

  // Model state: whether a result is being carried, bytes still owed, UART busy countdown.
  bit         engaged = 1'b0;
  int         bytes_left = 0;
  int         busy_cnt = 0;
  int         busy_len = 3;
  bit         hold_busy = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  typedef struct {
    logic [15:0] val;
    logic        wide;
    int          busy_len;
    int          n;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  alu_result_tx dut (
    .CLK       (clk),
    .RST       (rst),
    .ALU_OUT   (alu_out),
    .OUT_VALID (out_valid),
    .WIDE      (wide),
    .TX_BUSY   (tx_busy),
    .TX_P_DATA (tx_p_data),
    .TX_D_VLD  (tx_d_vld),
    .BUSY      (busy),
    .OVERRUN   (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample the handshake before the edge, then update model and compare after it.
  task automatic cycle();
    logic        acc, cap, drop, fin, cap_wide;
    logic [7:0]  d;
    logic [15:0] cap_val;
    acc      = tx_d_vld && !tx_busy;
    d        = tx_p_data;
    cap      = rst && out_valid && !engaged;
    drop     = rst && out_valid && engaged;
    fin      = rst && engaged && (bytes_left == 0) && tx_busy;
    cap_val  = alu_out;
    cap_wide = wide;
    @(posedge clk);
    @(negedge clk);
    out_valid = 1'b0;
    if (!rst) begin
      engaged    = 1'b0;
      bytes_left = 0;
      busy_cnt   = 0;
      exp_q.delete();
    end else begin
      if (acc) begin
        rx_q.push_back(d);
        bytes_left--;
        check("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("tx_byte", d, exp_q.pop_front());
      end
      if (cap) begin
        engaged    = 1'b1;
        bytes_left = cap_wide ? 2 : 1;
        exp_q.push_back(cap_val[7:0]);
        if (cap_wide) exp_q.push_back(cap_val[15:8]);
        check("latency_vld", tx_d_vld, 1);
      end else if (fin) begin
        engaged = 1'b0;
      end
      check("busy", busy, engaged);
      check("overrun", overrun, drop);
    end
    if (busy_cnt > 0) busy_cnt--;
    if (acc && rst) busy_cnt = busy_len;
    tx_busy = hold_busy || (busy_cnt != 0);
  endtask

  task automatic send(input logic [15:0] val, input logic w);
    alu_out   = val;
    wide      = w;
    out_valid = 1'b1;
    cycle();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while ((engaged || busy_cnt != 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    check("drain_done", engaged || (busy_cnt != 0), 0);
    check("exp_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    vecs[0] = '{16'hA55A, 1'b1, 10, 2, 8'h5A, 8'hA5};
    vecs[1] = '{16'h00F3, 1'b0, 3,  1, 8'hF3, 8'h00};
    vecs[2] = '{16'h0102, 1'b1, 2,  2, 8'h02, 8'h01};
    vecs[3] = '{16'hFFFF, 1'b0, 1,  1, 8'hFF, 8'h00};
    vecs[4] = '{16'h0000, 1'b1, 5,  2, 8'h00, 8'h00};
    vecs[5] = '{16'h8001, 1'b1, 1,  2, 8'h01, 8'h80};

    repeat (3) @(negedge clk);
    check("rst_data", tx_p_data, 0);
    check("rst_vld", tx_d_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // Release and capture on the very first edge after reset.
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      busy_len = vecs[i].busy_len;
      base = rx_q.size();
      send(vecs[i].val, vecs[i].wide);
      run_until_idle(100);
      check("vec_count", rx_q.size() - base, vecs[i].n);
      if (rx_q.size() > base) check("vec_lo", rx_q[base], vecs[i].lo);
      if (vecs[i].n == 2 && rx_q.size() > base + 1) check("vec_hi", rx_q[base+1], vecs[i].hi);
    end

    // Transmitter busy for 20 cycles while the low byte is offered.
    busy_len  = 4;
    hold_busy = 1'b1;
    tx_busy   = 1'b1;
    base = rx_q.size();
    send(16'hA55A, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check("hold_vld", tx_d_vld, 1);
      check("hold_data", tx_p_data, 8'h5A);
      cycle();
    end
    hold_busy = 1'b0;
    tx_busy   = (busy_cnt != 0);
    cycle();
    check("hold_accept_count", rx_q.size() - base, 1);
    if (rx_q.size() > base) check("hold_accept_byte", rx_q[base], 8'h5A);
    run_until_idle(100);
    check("hold_total", rx_q.size() - base, 2);

    // Second result mid-transfer is dropped with a single overrun pulse.
    busy_len = 10;
    base = rx_q.size();
    send(16'hA55A, 1'b1);
    repeat (3) cycle();
    alu_out   = 16'h1234;
    wide      = 1'b1;
    out_valid = 1'b1;
    cycle();
    check("ovr_pulse", overrun, 1);
    cycle();
    check("ovr_end", overrun, 0);
    run_until_idle(100);
    check("ovr_count", rx_q.size() - base, 2);
    if (rx_q.size() > base + 1) begin
      check("ovr_lo", rx_q[base], 8'h5A);
      check("ovr_hi", rx_q[base+1], 8'hA5);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        alu_out   = 16'($urandom);
        wide      = 1'($urandom_range(0, 1));
        out_valid = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) busy_len = $urandom_range(1, 6);
      cycle();
    end
    run_until_idle(200);

    // Reset while the high byte is on offer aborts the transfer.
    busy_len = 10;
    base = rx_q.size();
    send(16'hA55A, 1'b1);
    n = 0;
    while (!(tx_d_vld && tx_p_data == 8'hA5) && n < 60) begin
      cycle();
      n++;
    end
    check("reach_send_hi", tx_d_vld && (tx_p_data == 8'hA5), 1);
    rst = 1'b0;
    #1;
    check("abort_data", tx_p_data, 0);
    check("abort_vld", tx_d_vld, 0);
    check("abort_busy", busy, 0);
    check("abort_overrun", overrun, 0);
    @(negedge clk);
    cycle();
    cycle();
    check("abort_count", rx_q.size() - base, 1);
    rst = 1'b1;
    busy_len = 3;
    send(16'h0102, 1'b1);
    run_until_idle(100);
    check("post_rst_count", rx_q.size() - base, 3);
    if (rx_q.size() > base + 2) begin
      check("post_rst_lo", rx_q[base+1], 8'h02);
      check("post_rst_hi", rx_q[base+2], 8'h01);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
